// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the cipher datapaths.
//   - Nr / Nb / Nk        : AES-128 geometry
//   - encState_t          : one-hot FSM encoding (IDLE, START, RUN, LAST)
//   - SBOX / INV_SBOX     : forward and inverse substitution tables
//   - xtime/gmul2/gmul3   : GF(2^8) helpers, reduction polynomial 0x11b
// No ports (package).
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int Nr = 10;
    localparam int Nb = 4;
    localparam int Nk = 4;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        RUN   = 4'b0100,
        LAST  = 4'b1000
    } encState_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Used by the decryption datapath.
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Multiply by x in GF(2^8), reducing by 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

endpackage

// File: rtl/enc_round_fn.sv
// ---------------------------------------------------------------------------
// enc_round_fn
// Purely combinational AES forward round:
//   oData = [MixColumns](ShiftRows(SubBytes(iData))) ^ iKey
// Ports:
//   iData  in  128  round input state (byte n = bits [8n+7:8n], column-major)
//   iKey   in  128  round key
//   iLast  in  1    final round: MixColumns is bypassed
//   oData  out 128  round output state
// ---------------------------------------------------------------------------
module enc_round_fn
    import aes_pkg::*;
(
    input  logic [127:0] iData,
    input  logic [127:0] iKey,
    input  logic         iLast,
    output logic [127:0] oData
);

    logic [7:0] subB [16];
    logic [7:0] shiftB [16];
    logic [7:0] mixB [16];

    genvar gi, gj;
    generate
        for (gi = 0; gi < 16; gi++) begin : gSub
            assign subB[gi] = SBOX[iData[8*gi +: 8]];
        end

        // Row r of column c takes the byte from column (c + r) mod 4.
        for (gi = 0; gi < Nb; gi++) begin : gShiftCol
            for (gj = 0; gj < 4; gj++) begin : gShiftRow
                assign shiftB[4*gi + gj] = subB[4*((gi + gj) % 4) + gj];
            end
        end

        for (gi = 0; gi < Nb; gi++) begin : gMix
            logic [7:0] a0, a1, a2, a3;
            assign a0 = shiftB[4*gi + 0];
            assign a1 = shiftB[4*gi + 1];
            assign a2 = shiftB[4*gi + 2];
            assign a3 = shiftB[4*gi + 3];
            assign mixB[4*gi + 0] = gmul2(a0) ^ gmul3(a1) ^ a2 ^ a3;
            assign mixB[4*gi + 1] = a0 ^ gmul2(a1) ^ gmul3(a2) ^ a3;
            assign mixB[4*gi + 2] = a0 ^ a1 ^ gmul2(a2) ^ gmul3(a3);
            assign mixB[4*gi + 3] = gmul3(a0) ^ a1 ^ a2 ^ gmul2(a3);
        end

        for (gi = 0; gi < 16; gi++) begin : gOut
            assign oData[8*gi +: 8] = (iLast ? shiftB[gi] : mixB[gi]) ^ iKey[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/enccipher.sv
// ---------------------------------------------------------------------------
// enccipher
// Iterative AES-128 encryption core, one round per clock. Round keys arrive
// in parallel from the key expansion unit; a round waits until its key's
// ready bit is high.
// Ports:
//   iClk                 in  1    clock
//   iRstN                in  1    asynchronous reset, active-low
//   iEncStart            in  1    start request (honoured only when idle)
//   iEncData             in  128  plaintext, captured on start
//   iEncKeyRoundReady    in  11   bit r: iEncKeyRoundNN for round r is valid
//   iEncKeyRound00..10   in  128  round keys
//   oEncBusy             out 1    block in progress
//   oEncBlkEnd           out 1    one-cycle pulse, oEncData valid
//   oEncData             out 128  ciphertext, held until the next block ends
// ---------------------------------------------------------------------------
module enccipher
    import aes_pkg::*;
(
    input  logic         iClk,
    input  logic         iRstN,
    input  logic         iEncStart,
    input  logic [127:0] iEncData,
    input  logic [10:0]  iEncKeyRoundReady,
    input  logic [127:0] iEncKeyRound00,
    input  logic [127:0] iEncKeyRound01,
    input  logic [127:0] iEncKeyRound02,
    input  logic [127:0] iEncKeyRound03,
    input  logic [127:0] iEncKeyRound04,
    input  logic [127:0] iEncKeyRound05,
    input  logic [127:0] iEncKeyRound06,
    input  logic [127:0] iEncKeyRound07,
    input  logic [127:0] iEncKeyRound08,
    input  logic [127:0] iEncKeyRound09,
    input  logic [127:0] iEncKeyRound10,
    output logic         oEncBusy,
    output logic         oEncBlkEnd,
    output logic [127:0] oEncData
);

    encState_t    state;
    logic [3:0]   round;
    logic [127:0] data;

    // Keys and ready bits are padded to 16 entries so the 4-bit round
    // counter indexes them without an out-of-range case.
    logic [127:0] roundKeys [16];
    logic [15:0]  readyExt;
    logic [127:0] curKey;
    logic         roundReady;
    logic [127:0] roundOut;

    assign roundKeys[0]  = iEncKeyRound00;
    assign roundKeys[1]  = iEncKeyRound01;
    assign roundKeys[2]  = iEncKeyRound02;
    assign roundKeys[3]  = iEncKeyRound03;
    assign roundKeys[4]  = iEncKeyRound04;
    assign roundKeys[5]  = iEncKeyRound05;
    assign roundKeys[6]  = iEncKeyRound06;
    assign roundKeys[7]  = iEncKeyRound07;
    assign roundKeys[8]  = iEncKeyRound08;
    assign roundKeys[9]  = iEncKeyRound09;
    assign roundKeys[10] = iEncKeyRound10;

    genvar gi;
    generate
        for (gi = Nr + 1; gi < 16; gi++) begin : gKeyPad
            assign roundKeys[gi] = '0;
        end
    endgenerate

    assign readyExt   = {5'b0, iEncKeyRoundReady};
    assign curKey     = roundKeys[round];
    assign roundReady = readyExt[round];

    enc_round_fn uRound (
        .iData (data),
        .iKey  (curKey),
        .iLast (state == LAST),
        .oData (roundOut)
    );

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state      <= IDLE;
            round      <= '0;
            data       <= '0;
            oEncBusy   <= 1'b0;
            oEncBlkEnd <= 1'b0;
            oEncData   <= '0;
        end else begin
            oEncBlkEnd <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (iEncStart) begin
                        data     <= iEncData;
                        round    <= '0;
                        state    <= START;
                        oEncBusy <= 1'b1;
                    end
                end
                START: begin
                    if (roundReady) begin
                        data  <= data ^ curKey;
                        round <= 4'd1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (roundReady) begin
                        data  <= roundOut;
                        round <= round + 4'd1;
                        if (round == 4'(Nr - 1)) begin
                            state <= LAST;
                        end
                    end
                end
                LAST: begin
                    if (roundReady) begin
                        oEncData   <= roundOut;
                        oEncBlkEnd <= 1'b1;
                        oEncBusy   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    oEncBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enccipher.sv
// ---------------------------------------------------------------------------
// tb_enccipher
// Directed and random checks of the enccipher core against a byte-level AES
// reference model kept in this bench (S-box derived from the GF(2^8)
// inverse and affine map, generic GF multiply, FIPS-197 key schedule).
// ---------------------------------------------------------------------------
module tb_enccipher;

    localparam logic [127:0] KEY_C1  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] PT_C1   = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] CT_C1   = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    localparam logic [127:0] RK10_C1 = 128'hc5302b4d8ba707f3174a94e37f1d1113;
    localparam logic [127:0] KEY_B   = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [127:0] PT_B    = 128'h340737e0a29831318d305a88a8f64332;
    localparam logic [127:0] CT_B    = 128'h320b6a19978511dcfb09dc021d842539;

    logic         iClk = 1'b0;
    logic         iRstN = 1'b0;
    logic         iEncStart = 1'b0;
    logic [127:0] iEncData = '0;
    logic [10:0]  iEncKeyRoundReady = '0;
    logic [127:0] keyBus [11];
    logic         oEncBusy;
    logic         oEncBlkEnd;
    logic [127:0] oEncData;

    int errors = 0;
    int checks = 0;

    always #5 iClk = ~iClk;

    enccipher dut (
        .iClk              (iClk),
        .iRstN             (iRstN),
        .iEncStart         (iEncStart),
        .iEncData          (iEncData),
        .iEncKeyRoundReady (iEncKeyRoundReady),
        .iEncKeyRound00    (keyBus[0]),
        .iEncKeyRound01    (keyBus[1]),
        .iEncKeyRound02    (keyBus[2]),
        .iEncKeyRound03    (keyBus[3]),
        .iEncKeyRound04    (keyBus[4]),
        .iEncKeyRound05    (keyBus[5]),
        .iEncKeyRound06    (keyBus[6]),
        .iEncKeyRound07    (keyBus[7]),
        .iEncKeyRound08    (keyBus[8]),
        .iEncKeyRound09    (keyBus[9]),
        .iEncKeyRound10    (keyBus[10]),
        .oEncBusy          (oEncBusy),
        .oEncBlkEnd        (oEncBlkEnd),
        .oEncData          (oEncData)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]   sboxT [256];
    logic [127:0] curKeys [11];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] w = {b, b};
        return w[15-k -: 8];
    endfunction

    task automatic buildSbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = 8'h63;
            for (int k = 0; k < 5; k++) s ^= rotl8(inv, k);
            sboxT[x] = s;
        end
    endtask

    task automatic setKey(input logic [127:0] key);
        logic [7:0] w [176];
        logic [7:0] t [4];
        logic [7:0] rcon;
        logic [7:0] t0;
        rcon = 8'h01;
        for (int n = 0; n < 16; n++) w[n] = key[8*n +: 8];
        for (int i = 4; i < 44; i++) begin
            for (int k = 0; k < 4; k++) t[k] = w[4*(i-1) + k];
            if (i % 4 == 0) begin
                t0   = t[0];
                t[0] = sboxT[t[1]] ^ rcon;
                t[1] = sboxT[t[2]];
                t[2] = sboxT[t[3]];
                t[3] = sboxT[t0];
                rcon = gmul(rcon, 8'h02);
            end
            for (int k = 0; k < 4; k++) w[4*i + k] = w[4*(i-4) + k] ^ t[k];
        end
        for (int r = 0; r < 11; r++)
            for (int n = 0; n < 16; n++) curKeys[r][8*n +: 8] = w[16*r + n];
    endtask

    function automatic logic [127:0] aesEnc(input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [127:0] res;
        for (int n = 0; n < 16; n++) s[n] = pt[8*n +: 8] ^ curKeys[0][8*n +: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c + r] = sboxT[s[4*((c + r) % 4) + r]];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    s[4*c+0] = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c + r] = t[4*c + r];
                end
            end
            for (int n = 0; n < 16; n++) s[n] ^= curKeys[rnd][8*n +: 8];
        end
        for (int n = 0; n < 16; n++) res[8*n +: 8] = s[n];
        return res;
    endfunction

    // Protocol model: one block in flight; the next needed key round advances
    // whenever its ready bit is high. Ciphertext is computed at acceptance.
    logic         mActive = 1'b0;
    int           mNext = 0;
    logic [127:0] mCt = '0;
    logic [127:0] expData = '0;
    logic         expBlkEnd = 1'b0;

    always @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            mActive   <= 1'b0;
            mNext     <= 0;
            mCt       <= '0;
            expData   <= '0;
            expBlkEnd <= 1'b0;
        end else begin
            expBlkEnd <= 1'b0;
            if (!mActive) begin
                if (iEncStart) begin
                    mActive <= 1'b1;
                    mNext   <= 0;
                    mCt     <= aesEnc(iEncData);
                end
            end else if (iEncKeyRoundReady[mNext]) begin
                if (mNext == 10) begin
                    mActive   <= 1'b0;
                    expData   <= mCt;
                    expBlkEnd <= 1'b1;
                end else begin
                    mNext <= mNext + 1;
                end
            end
        end
    end

    // Compare process: outputs are meaningful on every cycle.
    always @(negedge iClk) begin
        check("cyc_busy", 128'(oEncBusy), 128'(mActive));
        check("cyc_blkend", 128'(oEncBlkEnd), 128'(expBlkEnd));
        check("cyc_data", oEncData, expData);
    end

    // ---------------- stimulus ----------------
    function automatic logic [10:0] readyFor(input int mode, input int k);
        logic [10:0] r;
        for (int i = 0; i < 11; i++) begin
            case (mode)
                0:       r[i] = 1'b1;
                1:       r[i] = (k >= 3*i);
                default: r[i] = ($urandom_range(0, 3) != 0);
            endcase
        end
        return r;
    endfunction

    // Keys not marked ready carry garbage.
    task automatic driveReady(input logic [10:0] rdy);
        iEncKeyRoundReady = rdy;
        for (int r = 0; r < 11; r++)
            keyBus[r] = rdy[r] ? curKeys[r] : {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // Called at a negedge: that cycle is cycle 0. Returns at the negedge of
    // the oEncBlkEnd cycle with lat = its cycle index.
    task automatic runBlock(input logic [127:0] pt, input int mode, input int pokeCycle,
                            input logic [127:0] pokeData, output int lat);
        iEncStart = 1'b1;
        iEncData  = pt;
        driveReady(readyFor(mode, 0));
        lat = -1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge iClk);
            iEncStart = 1'b0;
            iEncData  = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (oEncBlkEnd) begin
                lat = k;
                break;
            end
            if (k == pokeCycle) begin
                iEncStart = 1'b1;
                iEncData  = pokeData;
            end
            driveReady(readyFor(mode, k));
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL block_timeout: no oEncBlkEnd within 300 cycles");
        end
    endtask

    initial begin
        int lat;
        int pulses;
        logic [127:0] pt;
        logic [127:0] key;

        for (int r = 0; r < 11; r++) keyBus[r] = '0;
        buildSbox();

        // Pin the model to published values.
        check("model_sbox00", 128'(sboxT[8'h00]), 128'h63);
        check("model_sbox53", 128'(sboxT[8'h53]), 128'hed);
        check("model_gmul", 128'(gmul(8'h57, 8'h83)), 128'hc1);
        setKey(KEY_C1);
        check("model_rk10", curKeys[10], RK10_C1);
        check("model_c1", aesEnc(PT_C1), CT_C1);
        setKey(KEY_B);
        check("model_fipsb", aesEnc(PT_B), CT_B);

        // Reset state
        repeat (3) @(negedge iClk);
        check("reset_busy", 128'(oEncBusy), 128'h0);
        check("reset_blkend", 128'(oEncBlkEnd), 128'h0);
        check("reset_data", oEncData, 128'h0);
        iRstN = 1'b1;
        @(negedge iClk);

        // FIPS-197 C.1, all keys ready
        setKey(KEY_C1);
        runBlock(PT_C1, 0, -1, '0, lat);
        $display("txn c1: lat=%0d data=%h", lat, oEncData);
        check("c1_latency", 128'(lat), 128'd12);
        check("c1_data", oEncData, CT_C1);

        // Back-to-back: restart in the oEncBlkEnd cycle
        setKey(KEY_B);
        runBlock(PT_B, 0, -1, '0, lat);
        $display("txn b2b: lat=%0d data=%h", lat, oEncData);
        check("b2b_latency", 128'(lat), 128'd12);
        check("b2b_data", oEncData, CT_B);

        // Progressive key availability: ready[r] from cycle 3r
        @(negedge iClk);
        setKey(KEY_C1);
        runBlock(PT_C1, 1, -1, '0, lat);
        $display("txn progressive: lat=%0d data=%h", lat, oEncData);
        check("prog_latency", 128'(lat), 128'd31);
        check("prog_data", oEncData, CT_C1);

        // Start while busy is ignored
        @(negedge iClk);
        runBlock(PT_C1, 0, 5, PT_B, lat);
        $display("txn start_busy: lat=%0d data=%h", lat, oEncData);
        check("busy_latency", 128'(lat), 128'd12);
        check("busy_data", oEncData, CT_C1);
        repeat (3) @(negedge iClk);
        check("busy_no_restart", 128'(oEncBusy), 128'h0);

        // Reset mid-block
        iEncStart = 1'b1;
        iEncData  = PT_B;
        driveReady(11'h7ff);
        for (int k = 1; k <= 6; k++) begin
            @(negedge iClk);
            iEncStart = 1'b0;
        end
        iRstN = 1'b0;
        #1;
        $display("txn reset_mid: busy=%0d blkend=%0d data=%h", oEncBusy, oEncBlkEnd, oEncData);
        check("rst_busy", 128'(oEncBusy), 128'h0);
        check("rst_blkend", 128'(oEncBlkEnd), 128'h0);
        check("rst_data", oEncData, 128'h0);
        repeat (2) @(negedge iClk);
        iRstN  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge iClk);
            if (oEncBlkEnd) pulses++;
        end
        check("rst_no_pulse", 128'(pulses), 128'h0);
        runBlock(PT_C1, 0, -1, '0, lat);
        $display("txn after_reset: lat=%0d data=%h", lat, oEncData);
        check("rst_restart_latency", 128'(lat), 128'd12);
        check("rst_restart_data", oEncData, CT_C1);

        // Random keys, plaintexts and ready gaps
        for (int b = 0; b < 1000; b++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            setKey(key);
            runBlock(pt, 2, -1, '0, lat);
            $display("txn rand %0d: lat=%0d data=%h", b, lat, oEncData);
            check("rand_data", oEncData, aesEnc(pt));
            repeat ($urandom_range(0, 2)) begin
                @(negedge iClk);
                driveReady(readyFor(2, 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
